// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: four-way round-robin arbiter for one shared resource that is
// selected by a 2-bit case index. Grant is held while the owner keeps
// requesting. An optional hold limit forces release, and one dead cycle
// always separates consecutive owners.
module rr_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = $clog2(MAX_HOLD > 1 ? MAX_HOLD : 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  output logic [3:0]    gnt,
  output logic [1:0]    gnt_idx,
  output logic          gnt_valid,
  output logic          timeout,
  output logic [CW-1:0] busy_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    GAP  = 2'b10
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t     state;
  logic [1:0] last_idx;
  logic [1:0] rst_sync;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;
  logic       win_found;
  logic       hold_hit;

  // Reset synchronizer: assertion is asynchronous, release lands on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  // Round-robin pick: scan from the requester after last_idx; last_idx comes last
  always_comb begin
    logic [1:0] cand;
    win_idx   = last_idx;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_idx + 2'(k);
      if (!win_found && req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // One-hot decode of the winning index for the grant register
  always_comb begin
    case (win_idx)
      2'b00:   win_onehot = 4'b0001;
      2'b01:   win_onehot = 4'b0010;
      2'b10:   win_onehot = 4'b0100;
      2'b11:   win_onehot = 4'b1000;
      default: win_onehot = 4'b0000;
    endcase
  end

  // Forced release once the owner has held for MAX_HOLD cycles (never when MAX_HOLD is 0)
  always_comb begin
    hold_hit = (MAX_HOLD != 0) && (busy_cnt == HOLD_LAST);
  end

  // Arbiter FSM with registered grant, index, hold counter and timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      busy_cnt  <= '0;
      last_idx  <= '1;
    end else if (!rst_sync[1]) begin
      // Held in reset until the synchronized release reaches this edge
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      busy_cnt  <= '0;
      last_idx  <= '1;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          busy_cnt <= '0;
          if (win_found) begin
            state     <= BUSY;
            gnt       <= win_onehot;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // Forced release takes priority, so it reports timeout even if req drops too
          if (hold_hit || !req[gnt_idx]) begin
            state     <= GAP;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last_idx  <= gnt_idx;
            busy_cnt  <= '0;
            timeout   <= hold_hit;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          busy_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rr_sel_arbiter.md
Name: rr_sel_arbiter

Overview:
- Round-robin arbiter that shares one 2-bit-selected resource (a case-decoded mux/ALU slot) among 4 requesters.
- Registers a one-hot grant plus the matching 2-bit select index that drives the shared datapath's case selector.
- Grant is held while the owner keeps requesting. A hold-limit timeout forces release. A one-cycle dead gap is inserted between owners.
- Sits between requesting masters and the shared combinational resource.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per owner. 0 disables the timeout. Legal range 0 or 2..256.
- CW, $clog2(MAX_HOLD>1?MAX_HOLD:2): hold counter width. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-requester request, level-sensitive.
- gnt  output  4  registered one-hot grant; all zero when no owner.
- gnt_idx  output  2  registered index of current/last owner; drives the resource's case select.
- gnt_valid  output  1  high when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released.
- busy_cnt  output  CW  cycles the current owner has held the grant, starting at 0.

Behaviour:
Reset (async assert, sync deassert at the use point):
- gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, busy_cnt=0, state=IDLE.
- Internal last_idx=2'b11, so requester 0 has highest priority after reset.

States: IDLE, BUSY, GAP.
- The 2-bit state and index decodes are fully specified. Unused state encodings return to IDLE. No latches.

IDLE:
- req==0: stay in IDLE, outputs quiescent.
- Any req bit set: winner = first set bit scanning last_idx+1, last_idx+2, last_idx+3, last_idx (mod 4, wrap-around).
- Next cycle: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, busy_cnt=0, state=BUSY.
- Request-to-grant latency is 1 cycle.

BUSY:
- busy_cnt increments by 1 each cycle.
- Release when req[gnt_idx]==0 (normal), or when MAX_HOLD!=0 and busy_cnt==MAX_HOLD-1 (forced).
- On release, next cycle:
  - gnt=0, gnt_valid=0, state=GAP.
  - last_idx=gnt_idx; gnt_idx keeps its value.
  - busy_cnt=0.
  - timeout=1 only for a forced release.
- A forced release while req is still held counts as a timeout even if req drops in that same cycle. The forced-release condition wins.

GAP:
- Exactly 1 cycle with gnt=0; timeout deasserts after this cycle.
- Arbitration is evaluated in GAP using the updated last_idx, with the same rule as IDLE.
- Any req set: grant appears the cycle after GAP, state=BUSY. Otherwise go to IDLE.
- Owner-to-owner handoff therefore always shows exactly 1 cycle of gnt=0.

Other rules:
- The previous owner gets a new grant only if no other requester is active; it is evaluated last.
- Requests arriving or dropping during GAP are sampled only in GAP's arbitration cycle.
- Invariants: gnt is always zero or one-hot; gnt_valid == |gnt; when gnt_valid=1, gnt == onehot(gnt_idx).
- rst_n asserted mid-BUSY: outputs return to reset values immediately, without waiting for a clock edge. After release, arbitration restarts from requester 0.

Test Plan:
- Reset then req=4'b1111 held: grants rotate 0,1,2,3,0 with gnt_idx 00,01,10,11,00. Each owner holds 16 cycles, timeout pulses 1 cycle each, and 1 gap cycle separates owners.
- req=4'b0100 for 3 cycles then 0: gnt=4'b0100 one cycle after req, held 3 cycles, one GAP cycle, then IDLE; timeout never asserts.
- Owner 1 releases while req=4'b1010: next grant goes to 3 (not 1), and 1 is granted only after 3 releases.
- MAX_HOLD=0, req[2] held 300 cycles: gnt=4'b0100 continuously and timeout stays 0. busy_cnt wraps but causes no release.
- rst_n pulled low during a BUSY grant of owner 2 at busy_cnt=5: gnt=0, gnt_idx=0, busy_cnt=0 immediately. With req=4'b0101 after reset release, requester 0 is granted first.
- Random req for 10k cycles: checker confirms the invariants, no requester starves beyond 3*(MAX_HOLD+1) cycles, and every handoff has exactly 1 gap cycle.
